// File: rtl/pc_branch_unit.sv
// Program counter, flag register and run/halt control sitting behind the 8-bit ALU.
// Branches resolve against the stored flags; every output is registered.
module pc_branch_unit #(
   parameter int              PC_W       = 10,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    start,
   input  logic                    stall,
   input  logic                    halt_req,
   input  logic                    flag_we,
   input  logic                    zero_flag_in,
   input  logic                    parity_flag_in,
   input  logic                    not_equal_in,
   input  logic                    branch_en,
   input  logic [1:0]              branch_cond,
   input  logic                    branch_rel,
   input  logic [PC_W-1:0]         branch_target,
   input  logic signed [7:0]       branch_offset,
   output logic [PC_W-1:0]         prog_ctr,
   output logic                    halt,
   output logic                    done,
   output logic                    taken,
   output logic                    zero_q,
   output logic                    parity_q,
   output logic                    ne_q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t          state;
   logic            branch_hit;
   logic [PC_W-1:0] branch_addr;

   // The signed cast sign-extends the offset before the modulo-2**PC_W add.
   function automatic logic [PC_W-1:0] rel_addr(input logic [PC_W-1:0] pc,
                                                input logic signed [7:0] off);
      return pc + PC_W'(off);
   endfunction

   function automatic logic cond_met(input logic [1:0] cond, input logic z,
                                     input logic ne, input logic p);
      case (cond)
         2'b00:   return 1'b1;
         2'b01:   return z;
         2'b10:   return ne;
         default: return p;
      endcase
   endfunction

   assign branch_hit  = branch_en && cond_met(branch_cond, zero_q, ne_q, parity_q);
   assign branch_addr = branch_rel ? rel_addr(prog_ctr, branch_offset) : branch_target;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         prog_ctr <= START_ADDR;
         halt     <= 1'b1;
         done     <= 1'b0;
         taken    <= 1'b0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         ne_q     <= 1'b0;
      end else begin
         taken <= 1'b0;
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  state    <= RUN;
                  prog_ctr <= START_ADDR;
                  halt     <= 1'b0;
                  done     <= 1'b0;
                  zero_q   <= 1'b0;
                  parity_q <= 1'b0;
                  ne_q     <= 1'b0;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (flag_we) begin
                     zero_q   <= zero_flag_in;
                     parity_q <= parity_flag_in;
                     ne_q     <= not_equal_in;
                  end
                  // A halt leaves prog_ctr on the halt instruction itself.
                  if (halt_req) begin
                     state <= HALT;
                     halt  <= 1'b1;
                     done  <= 1'b1;
                  end else if (branch_hit) begin
                     prog_ctr <= branch_addr;
                     taken    <= 1'b1;
                  end else begin
                     prog_ctr <= prog_ctr + PC_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               halt  <= 1'b1;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: a behavioural model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_pc_branch_unit;

   localparam int PC_W = 10;
   localparam int DEPTH = 1 << PC_W;

   logic              Clk = 1'b0;
   logic              Reset, start, stall, halt_req, flag_we;
   logic              zero_flag_in, parity_flag_in, not_equal_in;
   logic              branch_en, branch_rel;
   logic [1:0]        branch_cond;
   logic [PC_W-1:0]   branch_target;
   logic signed [7:0] branch_offset;
   logic [PC_W-1:0]   prog_ctr;
   logic              halt, done, taken, zero_q, parity_q, ne_q;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   pc_branch_unit #(.PC_W(PC_W), .START_ADDR('0)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .stall(stall), .halt_req(halt_req),
      .flag_we(flag_we), .zero_flag_in(zero_flag_in), .parity_flag_in(parity_flag_in),
      .not_equal_in(not_equal_in), .branch_en(branch_en), .branch_cond(branch_cond),
      .branch_rel(branch_rel), .branch_target(branch_target), .branch_offset(branch_offset),
      .prog_ctr(prog_ctr), .halt(halt), .done(done), .taken(taken),
      .zero_q(zero_q), .parity_q(parity_q), .ne_q(ne_q)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int pc;
      bit running;
      bit halted;
      bit z, p, n;
      bit tk;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_next(mstate_t s);
      mstate_t r;
      bit      c;
      r    = s;
      r.tk = 1'b0;
      if (Reset) begin
         r.pc = 0; r.running = 0; r.halted = 0;
         r.z = 0; r.p = 0; r.n = 0;
      end else if (!s.running) begin
         if (start) begin
            r.running = 1; r.halted = 0; r.pc = 0;
            r.z = 0; r.p = 0; r.n = 0;
         end
      end else if (!stall) begin
         case (branch_cond)
            2'd0: c = 1'b1;
            2'd1: c = s.z;
            2'd2: c = s.n;
            default: c = s.p;
         endcase
         if (flag_we) begin
            r.z = zero_flag_in; r.p = parity_flag_in; r.n = not_equal_in;
         end
         if (halt_req) begin
            r.running = 0; r.halted = 1;
         end else if (branch_en && c) begin
            r.tk = 1'b1;
            if (branch_rel) r.pc = (s.pc + int'(branch_offset) + DEPTH) % DEPTH;
            else            r.pc = int'(branch_target);
         end else begin
            r.pc = (s.pc + 1) % DEPTH;
         end
      end
      return r;
   endfunction

   always @(posedge Clk) m <= model_next(m);

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("model prog_ctr", int'(prog_ctr), m.pc);
         chk("model halt", int'(halt), int'(!m.running));
         chk("model done", int'(done), int'(m.halted));
         chk("model taken", int'(taken), int'(m.tk));
         chk("model zero_q", int'(zero_q), int'(m.z));
         chk("model parity_q", int'(parity_q), int'(m.p));
         chk("model ne_q", int'(ne_q), int'(m.n));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr();
      start = 0; stall = 0; halt_req = 0; flag_we = 0;
      zero_flag_in = 0; parity_flag_in = 0; not_equal_in = 0;
      branch_en = 0; branch_cond = 2'd0; branch_rel = 0;
      branch_target = '0; branch_offset = '0;
   endtask

   task automatic br_abs(input int tgt, input int cond);
      branch_en = 1; branch_rel = 0; branch_cond = 2'(cond); branch_target = PC_W'(tgt);
   endtask

   task automatic br_rel(input logic [7:0] off, input int cond);
      branch_en = 1; branch_rel = 1; branch_cond = 2'(cond); branch_offset = off;
   endtask

   initial begin
      clr();
      Reset = 1;
      step();
      chk_en = 1'b1;
      step();
      chk("reset prog_ctr", int'(prog_ctr), 0);
      chk("reset halt", int'(halt), 1);
      chk("reset done", int'(done), 0);
      chk("reset flags", int'({zero_q, parity_q, ne_q}), 0);

      // run from start, sequential fetch
      Reset = 0; start = 1;
      step(); clr();
      chk("start halt", int'(halt), 0);
      chk("start pc", int'(prog_ctr), 0);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("seq pc", int'(prog_ctr), i);
      end
      repeat (6) step();
      chk("pc at 9", int'(prog_ctr), 9);

      // taken relative branch on zero_q, then not-taken
      flag_we = 1; zero_flag_in = 1;
      step(); clr();
      chk("zero_q load", int'(zero_q), 1);
      chk("pc at 10", int'(prog_ctr), 10);
      br_rel(8'hFC, 1);
      step(); clr();
      chk("rel back pc", int'(prog_ctr), 6);
      chk("taken pulse", int'(taken), 1);
      flag_we = 1; zero_flag_in = 0;
      step(); clr();
      chk("taken drop", int'(taken), 0);
      chk("pc 7", int'(prog_ctr), 8 - 1);
      br_rel(8'hFC, 1);
      step(); clr();
      chk("not taken pc", int'(prog_ctr), 8);
      chk("not taken flag", int'(taken), 0);

      // wrap-around cases
      br_abs(1023, 0); step(); clr();
      chk("abs 1023", int'(prog_ctr), 1023);
      step();
      chk("wrap inc", int'(prog_ctr), 0);
      br_abs(1021, 0); step(); clr();
      br_rel(8'd5, 0); step(); clr();
      chk("wrap rel +5", int'(prog_ctr), 2);
      step();
      br_rel(8'h80, 0); step(); clr();
      chk("wrap rel -128", int'(prog_ctr), 899);
      br_abs(512, 0); step(); clr();
      chk("abs 512", int'(prog_ctr), 512);

      // same-cycle flag write does not affect branch
      flag_we = 1; zero_flag_in = 1; br_rel(8'd16, 1);
      step(); clr();
      chk("same-cycle flag pc", int'(prog_ctr), 513);
      chk("same-cycle flag taken", int'(taken), 0);
      br_rel(8'd16, 1); step(); clr();
      chk("next-cycle flag pc", int'(prog_ctr), 529);
      flag_we = 1; zero_flag_in = 1; not_equal_in = 1; parity_flag_in = 0;
      step(); clr();
      br_rel(8'd2, 2); step(); clr();
      chk("ne branch pc", int'(prog_ctr), 532);
      br_rel(8'd2, 3); step(); clr();
      chk("parity not taken pc", int'(prog_ctr), 533);

      // halt beats branch
      br_abs(40, 0); step(); clr();
      halt_req = 1; br_abs(100, 0);
      step(); clr();
      chk("halt pc", int'(prog_ctr), 40);
      chk("halt done", int'(done), 1);
      chk("halt halt", int'(halt), 1);
      step();
      chk("halt hold pc", int'(prog_ctr), 40);
      start = 1; step();
      chk("restart pc", int'(prog_ctr), 0);
      chk("restart done", int'(done), 0);
      chk("restart flags", int'({zero_q, parity_q, ne_q}), 0);
      step(); clr();
      chk("start ignored in run", int'(prog_ctr), 1);

      // stall freezes everything; reset wins over stall
      flag_we = 1; zero_flag_in = 1; step(); clr();
      br_abs(37, 0); step(); clr();
      stall = 1; flag_we = 1; zero_flag_in = 0; parity_flag_in = 1; not_equal_in = 1;
      halt_req = 1; br_abs(200, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall pc", int'(prog_ctr), 37);
         chk("stall flags", int'({zero_q, parity_q, ne_q}), 4);
         chk("stall taken", int'(taken), 0);
         chk("stall halt", int'(halt), 0);
      end
      Reset = 1; step();
      chk("reset in stall pc", int'(prog_ctr), 0);
      chk("reset in stall halt", int'(halt), 1);
      chk("reset in stall done", int'(done), 0);
      Reset = 0; clr(); step();
      chk("idle hold pc", int'(prog_ctr), 0);
      chk("idle halt", int'(halt), 1);

      @(negedge Clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
